// File: rtl/emib_flash_req_ctrl_pkg.sv
// EMIB flash request controller: shared types and defaults.
// Integrators take ADDR_SZ_DEF / BOOT_LEN_DEF from here.
package emib_flash_req_ctrl_pkg;

  localparam int          ADDR_SZ_DEF  = 16;
  localparam logic [15:0] BOOT_LEN_DEF = 16'hb00;

  typedef enum logic [2:0] {
    ST_RST,
    ST_BOOT_REQ,
    ST_BOOT_BUSY,
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_BUSY
  } state_t;

  // index width that stays legal for a single entry
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/emib_flash_req_ctrl_if.sv
// Request/grant/done bundle between the controller and
// the flash interface module.
interface emib_flash_req_ctrl_if #(
  parameter int ADDR_SZ = 16
);

  logic               flash_rd_irq;
  logic               flash_rd_en;
  logic               read_flash_done;
  logic               flash_wr_irq;
  logic               flash_wr_en;
  logic               write_done;
  logic [ADDR_SZ-1:0] flash_addr_offset;
  logic [ADDR_SZ-1:0] flash_data_len;

  modport master (
    output flash_rd_irq,
    output flash_wr_irq,
    output flash_addr_offset,
    output flash_data_len,
    input  flash_rd_en,
    input  read_flash_done,
    input  flash_wr_en,
    input  write_done
  );

  modport slave (
    input  flash_rd_irq,
    input  flash_wr_irq,
    input  flash_addr_offset,
    input  flash_data_len,
    output flash_rd_en,
    output read_flash_done,
    output flash_wr_en,
    output write_done
  );

endinterface

// File: rtl/emib_flash_req_ctrl_timeout.sv
// Busy-cycle watchdog and per-region retry counter.
module emib_flash_timeout
  import emib_flash_req_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 65535,
  parameter int MAX_RETRY   = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic start,
  input  logic done,
  input  logic new_region,
  output logic expire,
  output logic exhausted
);

  localparam int CW = cw(TIMEOUT_CYC + 1);
  localparam int RW = cw(MAX_RETRY + 1);

  logic [CW-1:0] cnt;
  logic [RW-1:0] retry;

  // done in the expiring cycle wins
  assign expire = start && !done &&
                  (cnt == CW'(TIMEOUT_CYC - 1));
  assign exhausted = (retry == RW'(MAX_RETRY));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt   <= '0;
      retry <= '0;
    end else begin
      if (!start)
        cnt <= '0;
      else if (cnt != CW'(TIMEOUT_CYC))
        cnt <= cnt + 1'b1;
      if (new_region)
        retry <= '0;
      else if (expire && !exhausted)
        retry <= retry + 1'b1;
    end
  end

endmodule

// File: rtl/emib_flash_req_ctrl.sv
// Boot-loads all regions after reset, then saves regions
// to flash on demand with timeout and bounded retry.
module emib_flash_req_ctrl
  import emib_flash_req_ctrl_pkg::*;
#(
  parameter int ADDR_SZ     = ADDR_SZ_DEF,
  parameter int NUM_REGION  = 4,
  parameter int TIMEOUT_CYC = 65535,
  parameter int MAX_RETRY   = 2,
  localparam int IW = cw(NUM_REGION)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_device_state,
  input  logic [NUM_REGION-1:0]         i_save_req,
  input  logic [NUM_REGION*ADDR_SZ-1:0] i_region_offset,
  input  logic [NUM_REGION*ADDR_SZ-1:0] i_region_len,
  emib_flash_req_ctrl_if.master         bus,
  output logic [IW-1:0]                 o_region_idx,
  output logic                          o_busy,
  output logic                          o_boot_done,
  output logic                          o_err,
  output logic [NUM_REGION-1:0]         o_err_flag
);

  state_t state, state_n;

  logic [NUM_REGION-1:0] pend, pend_n, used;
  logic [IW-1:0]         cur, sel, nxt_idx, pend_idx;
  logic [ADDR_SZ-1:0]    offset, len;
  logic                  nxt_found, pend_found;
  logic                  load, boot_set, err_set;
  logic                  rd_irq, wr_irq, dev_q;
  logic                  busy_st, done_cur;
  logic                  expire, exhausted;
  int                    base;

  for (genvar g = 0; g < NUM_REGION; g++) begin : g_used
    assign used[g] = |i_region_len[g*ADDR_SZ +: ADDR_SZ];
  end

  assign busy_st  = (state == ST_BOOT_BUSY) ||
                    (state == ST_WR_BUSY);
  assign done_cur =
    ((state == ST_BOOT_BUSY) && bus.read_flash_done) ||
    ((state == ST_WR_BUSY)   && bus.write_done);

  emib_flash_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .MAX_RETRY   (MAX_RETRY)
  ) u_tmo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .start      (busy_st),
    .done       (done_cur),
    .new_region (load),
    .expire     (expire),
    .exhausted  (exhausted)
  );

  // next used region for boot, lowest pending for save
  always_comb begin
    base       = (state == ST_RST) ? 0 : int'(cur) + 1;
    nxt_found  = 1'b0;
    nxt_idx    = '0;
    pend_found = 1'b0;
    pend_idx   = '0;
    for (int k = NUM_REGION - 1; k >= 0; k--) begin
      if (used[k] && k >= base) begin
        nxt_found = 1'b1;
        nxt_idx   = IW'(k);
      end
      if (pend[k]) begin
        pend_found = 1'b1;
        pend_idx   = IW'(k);
      end
    end
  end

  always_comb begin
    state_n  = state;
    pend_n   = pend;
    sel      = nxt_idx;
    load     = 1'b0;
    boot_set = 1'b0;
    err_set  = 1'b0;
    unique case (state)
      ST_RST, ST_BOOT_BUSY: begin
        if (state == ST_RST || done_cur ||
            (expire && exhausted)) begin
          err_set = (state == ST_BOOT_BUSY) && !done_cur;
          if (nxt_found) begin
            state_n = ST_BOOT_REQ;
            load    = 1'b1;
          end else begin
            state_n  = ST_IDLE;
            boot_set = 1'b1;
          end
        end else if (expire) begin
          state_n = ST_BOOT_REQ;
        end
      end
      ST_BOOT_REQ:
        if (bus.flash_rd_en) state_n = ST_BOOT_BUSY;
      ST_IDLE:
        if (pend_found) begin
          pend_n[pend_idx] = 1'b0;
          if (used[pend_idx]) begin
            state_n = ST_WR_REQ;
            sel     = pend_idx;
            load    = 1'b1;
          end
        end
      ST_WR_REQ:
        if (bus.flash_wr_en) state_n = ST_WR_BUSY;
      ST_WR_BUSY:
        if (done_cur || (expire && exhausted)) begin
          err_set = !done_cur;
          state_n = ST_IDLE;
        end else if (expire) begin
          state_n = ST_WR_REQ;
        end
      default: state_n = ST_RST;
    endcase
    // new requests land after the clear so they survive it
    pend_n = pend_n | i_save_req |
             {NUM_REGION{i_device_state & ~dev_q}};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_RST;
      pend        <= '0;
      dev_q       <= 1'b0;
      cur         <= '0;
      offset      <= '1;
      len         <= '0;
      rd_irq      <= 1'b0;
      wr_irq      <= 1'b0;
      o_boot_done <= 1'b0;
      o_err       <= 1'b0;
      o_err_flag  <= '0;
    end else begin
      state  <= state_n;
      pend   <= pend_n;
      dev_q  <= i_device_state;
      rd_irq <= (state_n == ST_BOOT_REQ);
      wr_irq <= (state_n == ST_WR_REQ);
      o_err  <= err_set;
      if (err_set)  o_err_flag[cur] <= 1'b1;
      if (boot_set) o_boot_done <= 1'b1;
      if (load) begin
        cur    <= sel;
        offset <= i_region_offset[int'(sel)*ADDR_SZ +: ADDR_SZ];
        len    <= i_region_len[int'(sel)*ADDR_SZ +: ADDR_SZ];
      end
    end
  end

  assign bus.flash_rd_irq      = rd_irq;
  assign bus.flash_wr_irq      = wr_irq;
  assign bus.flash_addr_offset = offset;
  assign bus.flash_data_len    = len;
  assign o_region_idx          = cur;
  assign o_busy                = (state != ST_IDLE);

endmodule

// File: tb/tb_emib_flash_req_ctrl.sv
// Scoreboard bench for emib_flash_req_ctrl with an
// auto-responding flash interface model.
module tb_emib_flash_req_ctrl;

  localparam int AW = 16;
  localparam int NR = 4;

  logic          clk, rst, dev;
  logic [NR-1:0] save_req;
  logic [NR*AW-1:0] roff, rlen;
  logic [1:0]    ridx_o;
  logic          busy, boot_done, err;
  logic [NR-1:0] err_flag;

  emib_flash_req_ctrl_if #(.ADDR_SZ(AW)) bus();

  emib_flash_req_ctrl #(
    .ADDR_SZ     (AW),
    .NUM_REGION  (NR),
    .TIMEOUT_CYC (8),
    .MAX_RETRY   (2)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_device_state  (dev),
    .i_save_req      (save_req),
    .i_region_offset (roff),
    .i_region_len    (rlen),
    .bus             (bus.master),
    .o_region_idx    (ridx_o),
    .o_busy          (busy),
    .o_boot_done     (boot_done),
    .o_err           (err),
    .o_err_flag      (err_flag)
  );

  typedef struct packed {
    logic          wr;
    logic [1:0]    idx;
    logic [AW-1:0] off;
    logic [AW-1:0] len;
  } req_t;

  req_t          expq[$];
  int            nchk = 0;
  int            nerr = 0;
  int            err_cnt = 0;
  logic [AW-1:0] cfg_off[NR];
  logic [AW-1:0] cfg_len[NR];
  logic          hang;
  int            hang_idx;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_req(input logic wr, input int k);
    req_t r;
    r.wr  = wr;
    r.idx = 2'(k);
    r.off = cfg_off[k];
    r.len = cfg_len[k];
    expq.push_back(r);
  endtask

  task automatic apply_cfg();
    for (int k = 0; k < NR; k++) begin
      roff[k*AW +: AW] = cfg_off[k];
      rlen[k*AW +: AW] = cfg_len[k];
    end
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_rdirq"}, 64'(bus.flash_rd_irq), 64'd0);
    chk({t, "_wrirq"}, 64'(bus.flash_wr_irq), 64'd0);
    chk({t, "_off"}, 64'(bus.flash_addr_offset), 64'hffff);
    chk({t, "_len"}, 64'(bus.flash_data_len), 64'd0);
    chk({t, "_idx"}, 64'(ridx_o), 64'd0);
    chk({t, "_busy"}, 64'(busy), 64'd1);
    chk({t, "_bootdone"}, 64'(boot_done), 64'd0);
    chk({t, "_err"}, 64'(err), 64'd0);
    chk({t, "_errflag"}, 64'(err_flag), 64'd0);
  endtask

  task automatic wait_boot(input string tag);
    int n = 0;
    while (!boot_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(boot_done), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((expq.size() != 0 || busy) && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_q"}, 64'(expq.size()), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  // flash module: grant 3 cycles after irq, done 3 later
  initial begin
    int   rcnt;
    logic is_rd;
    int   ridx;
    rcnt = 0;
    is_rd = 0;
    ridx = 0;
    bus.flash_rd_en     = 0;
    bus.flash_wr_en     = 0;
    bus.read_flash_done = 0;
    bus.write_done      = 0;
    forever begin
      @(negedge clk);
      bus.flash_rd_en     = 0;
      bus.flash_wr_en     = 0;
      bus.read_flash_done = 0;
      bus.write_done      = 0;
      if (rst) begin
        rcnt = 0;
      end else if (rcnt == 0) begin
        if (bus.flash_rd_irq || bus.flash_wr_irq) begin
          rcnt  = 1;
          is_rd = bus.flash_rd_irq;
          ridx  = int'(ridx_o);
        end
      end else begin
        rcnt++;
        if (rcnt == 3) begin
          if (is_rd) bus.flash_rd_en = 1;
          else bus.flash_wr_en = 1;
        end
        if (rcnt == 6) begin
          if (!(hang && ridx == hang_idx)) begin
            if (is_rd) bus.read_flash_done = 1;
            else bus.write_done = 1;
          end
          rcnt = 0;
        end
      end
    end
  end

  // scoreboard: every irq rising edge pops one entry
  initial begin
    logic prd, pwr;
    req_t r, e;
    prd = 0;
    pwr = 0;
    forever begin
      @(negedge clk);
      if (err === 1'b1) err_cnt++;
      if ((bus.flash_rd_irq && !prd) ||
          (bus.flash_wr_irq && !pwr)) begin
        r.wr  = bus.flash_wr_irq;
        r.idx = ridx_o;
        r.off = bus.flash_addr_offset;
        r.len = bus.flash_data_len;
        chk("req_queued", 64'(expq.size() != 0), 64'd1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk("req_kind_idx", 64'({r.wr, r.idx}),
              64'({e.wr, e.idx}));
          chk("req_off_len", 64'({r.off, r.len}),
              64'({e.off, e.len}));
          if (r.wr)
            chk("wr_after_boot", 64'(boot_done), 64'd1);
        end
      end
      prd = bus.flash_rd_irq;
      pwr = bus.flash_wr_irq;
    end
  end

  initial begin
    int n;
    rst = 1;
    dev = 0;
    save_req = '0;
    hang = 0;
    hang_idx = 0;
    for (int k = 0; k < NR; k++) begin
      cfg_off[k] = AW'(k * 'h400);
      cfg_len[k] = 16'h100;
    end

    // boot with region 1 unused
    cfg_len[1] = '0;
    apply_cfg();
    repeat (3) @(negedge clk);
    chk_reset("rst0");
    expect_req(0, 0);
    expect_req(0, 2);
    expect_req(0, 3);
    rst = 0;
    wait_boot("skip_boot");
    wait_idle("skip");

    // full four-region boot
    cfg_len[1] = 16'h100;
    apply_cfg();
    @(negedge clk);
    rst = 1;
    for (int k = 0; k < NR; k++) expect_req(0, k);
    @(negedge clk);
    rst = 0;
    wait_boot("full_boot");
    wait_idle("full");

    // device_state rise saves everything once
    for (int k = 0; k < NR; k++) expect_req(1, k);
    dev = 1;
    wait_idle("dev_save");
    repeat (40) @(negedge clk);
    wait_idle("dev_hold");
    dev = 0;

    // region 2 never completes
    hang = 1;
    hang_idx = 2;
    err_cnt = 0;
    repeat (3) expect_req(1, 2);
    expect_req(1, 3);
    save_req = 4'b1100;
    @(negedge clk);
    save_req = '0;
    wait_idle("tmo");
    chk("tmo_err_pulses", 64'(err_cnt), 64'd1);
    chk("tmo_err_flag", 64'(err_flag), 64'b0100);
    hang = 0;

    // save request raised mid-boot waits for boot
    @(negedge clk);
    rst = 1;
    #1 chk_reset("rst_e");
    for (int k = 0; k < NR; k++) expect_req(0, k);
    expect_req(1, 3);
    @(negedge clk);
    rst = 0;
    n = 0;
    while (!bus.flash_rd_irq && n < 50) begin
      @(negedge clk);
      n++;
    end
    while (bus.flash_rd_irq && n < 100) begin
      @(negedge clk);
      n++;
    end
    save_req = 4'b1000;
    @(negedge clk);
    save_req = '0;
    wait_boot("sdb_boot");
    wait_idle("sdb");

    // reset in the middle of a save
    expect_req(1, 0);
    save_req = 4'b0001;
    @(negedge clk);
    save_req = '0;
    n = 0;
    while (!bus.flash_wr_irq && n < 50) begin
      @(negedge clk);
      n++;
    end
    while (bus.flash_wr_irq && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid_in_busy", 64'(busy), 64'd1);
    #2 rst = 1;
    #1 chk_reset("midrst");
    for (int k = 0; k < NR; k++) expect_req(0, k);
    @(negedge clk);
    rst = 0;
    wait_boot("post_boot");
    repeat (30) @(negedge clk);
    wait_idle("post_rst");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
